// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and defaults for the instruction-memory access arbiter
package imem_arb_pkg;

  // Default instruction-memory word-address width (64 words)
  localparam int unsigned IMEM_ADDR_W = 6;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    LOAD    = 2'd2,
    RESTART = 2'd3
  } arb_state_t;

endpackage

// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - shares the instruction memory between fetch and the program loader
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned DRAIN_CYC = 4,
  parameter logic [31:0] START_PC  = 32'h0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_grant,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              StallF,
  output logic              FlushD,
  output logic              pc_restart,
  output logic [31:0]       pc_restart_addr,
  output logic [ADDR_W:0]   words_written,
  output logic              busy
);

  // Drain counter runs 0..DRAIN_CYC-1; keep at least one bit for DRAIN_CYC == 1
  localparam int unsigned       CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   WW_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              accept;

  // A loader word is taken whenever it is offered while the loader owns the memory
  assign accept = (state_q == LOAD) && ld_valid;

  // State, drain counter and word count registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ww_q    <= ww_d;
    end
  end

  // Next-state: halt fetch, drain the pipe, grant the loader, then restart fetch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ww_d    = ww_q;
    unique case (state_q)
      RUN: begin
        if (ld_req) begin
          state_d = DRAIN;
          cnt_d   = '0;
          ww_d    = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The MSB is only set at exactly 2^ADDR_W, so it marks saturation
        if (accept && !ww_q[ADDR_W]) begin
          ww_d = ww_q + WW_ONE;
        end
        // A dropped request aborts the load; words already written are kept
        if ((accept && ld_last) || !ld_req) begin
          state_d = RESTART;
        end
      end
      RESTART: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Outputs: Moore from state, except the memory port which follows the loader in LOAD
  always_comb begin
    ld_ready   = 1'b0;
    ld_grant   = 1'b0;
    imem_addr  = fetch_addr;
    imem_we    = 1'b0;
    imem_wdata = 32'h0;
    StallF     = 1'b0;
    FlushD     = 1'b0;
    pc_restart = 1'b0;
    busy       = (state_q != RUN);
    unique case (state_q)
      RUN: begin
      end
      DRAIN: begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
      LOAD: begin
        StallF     = 1'b1;
        FlushD     = 1'b1;
        ld_grant   = 1'b1;
        ld_ready   = 1'b1;
        imem_addr  = ld_addr;
        imem_wdata = ld_wdata;
        // A write landing in a reset cycle must not reach the memory
        imem_we    = accept && !reset;
      end
      RESTART: begin
        FlushD     = 1'b1;
        pc_restart = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_restart_addr = START_PC;
  assign words_written   = ww_q;

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
Shares the single-port instruction memory between the fetch stage (read every cycle) and a program-loader requester (debug/UART path writing instruction words). A 4-state FSM halts fetch, drains in-flight instructions, grants the memory to the loader, then restarts fetch at a programmable PC. It sits beside the fetch stage and drives the fetch stall, decode flush and PC-restart controls.

Parameters:
ADDR_W, 6, instruction-memory word-address width (64 words)
DRAIN_CYC, 4, cycles fetch is held before loader grant (pipeline depth minus 1)
START_PC, 32'h0, byte PC loaded into the fetch stage on restart

Ports:
CLK  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
fetch_addr  input  ADDR_W  fetch word address (PCF[ADDR_W+1:2])
ld_req  input  1  loader requests memory ownership (level)
ld_valid  input  1  loader write word valid
ld_addr  input  ADDR_W  loader write word address
ld_wdata  input  32  loader write data
ld_last  input  1  qualifies final word of the load
ld_ready  output  1  arbiter accepts a loader word this cycle
ld_grant  output  1  loader owns the memory (LOAD state)
imem_addr  output  ADDR_W  memory word address
imem_we  output  1  memory write enable
imem_wdata  output  32  memory write data
StallF  output  1  hold PCF
FlushD  output  1  bubble the IF/ID register
pc_restart  output  1  one-cycle pulse: fetch loads pc_restart_addr
pc_restart_addr  output  32  always START_PC
words_written  output  ADDR_W+1  words written in the current/last load, saturating
busy  output  1  state != RUN

Behaviour:
- Reset: state=RUN, drain counter=0, words_written=0; all control outputs 0; imem_addr=fetch_addr.
- States: RUN, DRAIN, LOAD, RESTART. Outputs are Moore from state except imem_we/imem_addr/imem_wdata in LOAD.
- RUN: imem_addr=fetch_addr, imem_we=0, StallF=0, FlushD=0. If ld_req=1 at posedge -> DRAIN, counter cleared, words_written cleared.
- DRAIN: StallF=1, FlushD=1, ld_ready=0. Counter increments each cycle; when counter==DRAIN_CYC-1 -> LOAD. Total DRAIN occupancy exactly DRAIN_CYC cycles. ld_req deassertion during DRAIN is ignored (load still granted).
- LOAD: StallF=1, FlushD=1, ld_grant=1, ld_ready=1. Accept = ld_valid & ld_ready. On accept: imem_we=1, imem_addr=ld_addr, imem_wdata=ld_wdata combinationally in the same cycle; words_written+1, saturating at 2^ADDR_W. Without accept, imem_we=0, imem_addr=ld_addr. Accept with ld_last=1 -> RESTART (that word is written). ld_last without ld_valid is ignored. ld_req dropping to 0 in LOAD without ld_last -> RESTART (abort, words already written kept).
- RESTART: one cycle; pc_restart=1, StallF=0, FlushD=1, imem_addr=fetch_addr; -> RUN. The fetch stage gives pc_restart priority over StallF and all branch/jr redirects.
- Latency: ld_req to ld_ready = DRAIN_CYC+1 cycles; last accept to first fetch at START_PC = 2 cycles.
- ld_req still high on returning to RUN starts a new load on the next posedge (level semantics; the loader drops ld_req after ld_last).
- Reset in any state: same-cycle transition to reset values; an in-progress write in that cycle is suppressed (imem_we=0 while reset=1).
- Address wrap: ld_addr used as-is, no bounds check (ADDR_W covers the memory).

Decomposition:
- Shared package imem_arb_pkg: enum arb_state_t {RUN, DRAIN, LOAD, RESTART}, default IMEM_ADDR_W=6.
- Single module; drain counter inlined (no sub-module warranted).

Test Plan:
- Idle: ld_req=0, fetch_addr sweeps 0..63 -> imem_addr tracks it, imem_we=0, StallF=0, busy=0 on every cycle.
- Basic load: ld_req at cycle 10 -> StallF/FlushD high cycles 11-14, ld_ready at 15; write words 0xA0..0xA3 to addr 0..3 with ld_last on the 4th -> 4 writes, words_written=4, pc_restart pulse at cycle 19, RUN at 20.
- Backpressure gaps: ld_valid toggling 1,0,1,0 in LOAD -> imem_we mirrors ld_valid exactly, words_written counts only accepts.
- Abort: ld_req drops after 2 accepted words, no ld_last -> RESTART next cycle, words_written=2, pc_restart=1 for one cycle.
- Reset mid-LOAD with ld_valid=1 -> imem_we=0 that cycle, state RUN, all outputs at reset values next cycle.
- Saturation/back-to-back: 70 accepted writes -> words_written=64; ld_req held through RESTART -> DRAIN again one cycle after RUN.
